// File: rtl/impulse_readout_sequencer_if.sv
// Bundle of the sequencer's control, counter-bank and serial-frame signals.
// The master modport is the sequencer side; the slave modport is the bank/host side.
interface impulse_readout_sequencer_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 16
);
    localparam int ADDR_W = $clog2(N_CH);

    logic              en;
    logic              rtc_tick;
    logic              ovf_clr;
    logic [CNT_W-1:0]  cnt_data;
    logic [N_CH-1:0]   ovf_in;
    logic              snap;
    logic [ADDR_W-1:0] ch_addr;
    logic              sl;
    logic              serial_out;
    logic              frame_valid;
    logic              done;
    logic              ovf_global;
    logic              ovf_rtc;
    logic              busy;

    modport master (
        input  en, rtc_tick, ovf_clr, cnt_data, ovf_in,
        output snap, ch_addr, sl, serial_out, frame_valid, done,
               ovf_global, ovf_rtc, busy
    );

    modport slave (
        output en, rtc_tick, ovf_clr, cnt_data, ovf_in,
        input  snap, ch_addr, sl, serial_out, frame_valid, done,
               ovf_global, ovf_rtc, busy
    );
endinterface

// File: rtl/impulse_readout_sequencer.sv
// Snapshots the impulse counter bank on each RTC tick and streams every channel
// as {overflow, count} MSB first; flags ticks that arrive during a frame.
module impulse_readout_sequencer #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    impulse_readout_sequencer_if.master bus
);
    localparam int ADDR_W = $clog2(N_CH);
    localparam int BC_W   = $clog2(CNT_W + 1);
    localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(N_CH - 32'd1);
    localparam logic [ADDR_W-1:0] CH_ONE  = ADDR_W'(32'd1);
    localparam logic [BC_W-1:0]   BC_INIT = BC_W'(CNT_W);
    localparam logic [BC_W-1:0]   BC_ONE  = BC_W'(32'd1);
    localparam logic [BC_W-1:0]   BC_ZERO = BC_W'(32'd0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNAP  = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t            state_r, next_state_s;
    logic [ADDR_W-1:0] idx_r, next_idx_s;
    logic [BC_W-1:0]   bit_cnt_r, next_bit_cnt_s;
    logic [CNT_W:0]    shreg_r, next_shreg_s;
    logic              ovf_global_r, next_ovf_global_s;
    logic              ovf_rtc_r, next_ovf_rtc_s;
    logic              done_s;
    logic              tick_s;

    logic              snap_r;
    logic [ADDR_W-1:0] ch_addr_r;
    logic              sl_r;
    logic              serial_out_r;
    logic              frame_valid_r;
    logic              done_r;
    logic              busy_r;

    assign tick_s = bus.rtc_tick & bus.en;

    // Next-state, datapath and missed-tick flag logic.
    always_comb begin
        next_state_s      = state_r;
        next_idx_s        = idx_r;
        next_bit_cnt_s    = bit_cnt_r;
        next_shreg_s      = shreg_r;
        next_ovf_global_s = ovf_global_r;
        done_s            = 1'b0;

        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    next_state_s      = SNAP;
                    next_idx_s        = {ADDR_W{1'b0}};
                    next_ovf_global_s = 1'b0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SNAP: begin
                next_state_s = LOAD;
            end
            LOAD: begin
                next_shreg_s      = {bus.ovf_in[idx_r], bus.cnt_data};
                next_ovf_global_s = ovf_global_r | bus.ovf_in[idx_r];
                next_bit_cnt_s    = BC_INIT;
                next_state_s      = SHIFT;
            end
            SHIFT: begin
                next_shreg_s = {shreg_r[CNT_W-1:0], 1'b0};
                // Counter at zero marks the cycle carrying the count LSB.
                if (bit_cnt_r == BC_ZERO) begin
                    if (idx_r == LAST_CH) begin
                        next_state_s = IDLE;
                        done_s       = 1'b1;
                    end else begin
                        next_idx_s   = idx_r + CH_ONE;
                        next_state_s = LOAD;
                    end
                end else begin
                    next_bit_cnt_s = bit_cnt_r - BC_ONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase

        // A missed tick outranks a simultaneous clear.
        if (tick_s && (state_r != IDLE)) begin
            next_ovf_rtc_s = 1'b1;
        end else if (bus.ovf_clr) begin
            next_ovf_rtc_s = 1'b0;
        end else begin
            next_ovf_rtc_s = ovf_rtc_r;
        end
    end

    // State, datapath and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            idx_r         <= {ADDR_W{1'b0}};
            bit_cnt_r     <= {BC_W{1'b0}};
            shreg_r       <= {(CNT_W + 1){1'b0}};
            ovf_global_r  <= 1'b0;
            ovf_rtc_r     <= 1'b0;
            snap_r        <= 1'b0;
            ch_addr_r     <= {ADDR_W{1'b0}};
            sl_r          <= 1'b0;
            serial_out_r  <= 1'b0;
            frame_valid_r <= 1'b0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            idx_r         <= next_idx_s;
            bit_cnt_r     <= next_bit_cnt_s;
            shreg_r       <= next_shreg_s;
            ovf_global_r  <= next_ovf_global_s;
            ovf_rtc_r     <= next_ovf_rtc_s;
            snap_r        <= (next_state_s == SNAP);
            ch_addr_r     <= next_idx_s;
            sl_r          <= (next_state_s == LOAD);
            serial_out_r  <= (next_state_s == SHIFT) & next_shreg_s[CNT_W];
            frame_valid_r <= (next_state_s == SHIFT);
            done_r        <= done_s;
            busy_r        <= (next_state_s != IDLE);
        end
    end

    assign bus.snap        = snap_r;
    assign bus.ch_addr     = ch_addr_r;
    assign bus.sl          = sl_r;
    assign bus.serial_out  = serial_out_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.done        = done_r;
    assign bus.ovf_global  = ovf_global_r;
    assign bus.ovf_rtc     = ovf_rtc_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_impulse_readout_sequencer.sv
// Directed bench: default 8x16 instance plus a 2x4 instance, checked against
// hand-computed frames, timing and missed-tick flag behaviour.
module tb_impulse_readout_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    impulse_readout_sequencer_if #(.N_CH(8), .CNT_W(16)) ifa ();
    impulse_readout_sequencer_if #(.N_CH(2), .CNT_W(4))  ifb ();

    impulse_readout_sequencer #(.N_CH(8), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    impulse_readout_sequencer #(.N_CH(2), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // Counter bank models: combinational count per addressed channel.
    always_comb ifa.cnt_data = 16'hA5C3 + {13'd0, ifa.ch_addr};
    always_comb ifb.cnt_data = 4'hA + {3'd0, ifb.ch_addr};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick_a();
        ifa.rtc_tick = 1'b1;
        step();
        ifa.rtc_tick = 1'b0;
    endtask

    // Called in the snap cycle; follows one whole frame of the default instance.
    task automatic watch_a(input logic [7:0] ovf, input int miss_at, input logic clr_miss,
                           input logic chain, input string tag);
        int cyc = 0, sl_cnt = 0, nbits = 0, gl_err = 0, addr_err = 0, done_at = -1, ch;
        logic busy_at_done = 1'b1;
        logic glob_at_done = 1'b0;
        logic exp_g = 1'b0;
        logic [16:0] word = 17'd0;
        ifa.ovf_in = ovf;
        check($sformatf("%s_snap_busy", tag), {ifa.snap, ifa.busy}, 2'b11);
        while (done_at < 0 && cyc < 300) begin
            if (ifa.ovf_global !== exp_g) gl_err++;
            if (ifa.sl === 1'b1) begin
                if (ifa.ch_addr !== 3'(sl_cnt)) addr_err++;
                if (ovf[ifa.ch_addr] === 1'b1) exp_g = 1'b1;
                sl_cnt++;
            end
            if (ifa.frame_valid === 1'b1) begin
                if (ifa.ch_addr !== 3'(sl_cnt - 1)) addr_err++;
                word = {word[15:0], ifa.serial_out};
                nbits++;
                if (nbits % 17 == 0) begin
                    ch = nbits / 17 - 1;
                    check($sformatf("%s_ch%0d", tag, ch), word, {ovf[ch], 16'hA5C3 + 16'(ch)});
                end
            end else if (ifa.serial_out !== 1'b0) begin
                addr_err++;
            end
            if (cyc > 0 && ifa.snap === 1'b1) addr_err++;
            if (ifa.done === 1'b1) begin
                done_at      = cyc;
                busy_at_done = ifa.busy;
                glob_at_done = ifa.ovf_global;
            end
            ifa.rtc_tick = (cyc == miss_at) || (chain && done_at >= 0);
            ifa.ovf_clr  = (cyc == miss_at) && clr_miss;
            step();
            cyc++;
        end
        ifa.rtc_tick = 1'b0;
        ifa.ovf_clr  = 1'b0;
        check($sformatf("%s_done_lat", tag), 64'(done_at), 64'd145);
        check($sformatf("%s_busy_at_done", tag), busy_at_done, 1'b0);
        check($sformatf("%s_sl_count", tag), 64'(sl_cnt), 64'd8);
        check($sformatf("%s_bit_count", tag), 64'(nbits), 64'd136);
        check($sformatf("%s_glob_track", tag), 64'(gl_err), 64'd0);
        check($sformatf("%s_addr_bus", tag), 64'(addr_err), 64'd0);
        check($sformatf("%s_glob_done", tag), glob_at_done, |ovf);
    endtask

    initial begin
        int bcyc, busy_cnt, nb;
        logic saw1, done_seen;
        logic [9:0] bits;

        rst_n = 1'b0;
        ifa.en = 1'b1; ifa.rtc_tick = 1'b0; ifa.ovf_clr = 1'b0; ifa.ovf_in = 8'h00;
        ifb.en = 1'b1; ifb.rtc_tick = 1'b0; ifb.ovf_clr = 1'b0; ifb.ovf_in = 2'b00;
        repeat (3) step();
        check("reset_a", {ifa.snap, ifa.ch_addr, ifa.sl, ifa.serial_out, ifa.frame_valid,
                          ifa.done, ifa.ovf_global, ifa.ovf_rtc, ifa.busy}, 11'd0);
        check("reset_b", {ifb.snap, ifb.ch_addr, ifb.busy, ifb.frame_valid}, 4'd0);
        rst_n = 1'b1;
        repeat (4) step();
        check("idle_quiet", {ifa.busy, ifa.snap, ifa.frame_valid}, 3'b000);

        pulse_tick_a();
        watch_a(8'h00, -1, 1'b0, 1'b0, "f0");

        pulse_tick_a();
        watch_a(8'h24, -1, 1'b0, 1'b0, "ovf");
        repeat (3) step();
        check("ovf_hold", ifa.ovf_global, 1'b1);

        // Tick on the done cycle starts the next frame straight away.
        pulse_tick_a();
        watch_a(8'h00, -1, 1'b0, 1'b1, "chain_a");
        check("chain_snap", {ifa.snap, ifa.busy, ifa.ovf_rtc}, 3'b110);
        watch_a(8'h00, -1, 1'b0, 1'b0, "chain_b");

        pulse_tick_a();
        watch_a(8'h00, 50, 1'b0, 1'b0, "miss");
        check("miss_flag", ifa.ovf_rtc, 1'b1);
        repeat (4) step();
        check("miss_no_frame", {ifa.busy, ifa.snap}, 2'b00);

        ifa.ovf_clr = 1'b1;
        step();
        ifa.ovf_clr = 1'b0;
        check("clr_alone", ifa.ovf_rtc, 1'b0);

        pulse_tick_a();
        watch_a(8'h81, 60, 1'b1, 1'b0, "missclr");
        check("set_wins", ifa.ovf_rtc, 1'b1);
        ifa.ovf_clr = 1'b1;
        step();
        ifa.ovf_clr = 1'b0;
        check("clr_again", ifa.ovf_rtc, 1'b0);

        ifa.en = 1'b0;
        pulse_tick_a();
        check("en_off", {ifa.snap, ifa.busy, ifa.ovf_rtc}, 3'b000);
        step();
        check("en_off_later", {ifa.snap, ifa.busy}, 2'b00);
        ifa.en = 1'b1;

        // Abandon a frame mid-SHIFT with flags and address non-zero.
        ifa.ovf_in = 8'hFF;
        pulse_tick_a();
        repeat (5) step();
        pulse_tick_a();
        repeat (14) step();
        check("pre_rst_shift", {ifa.frame_valid, ifa.ch_addr, ifa.ovf_global, ifa.ovf_rtc}, 6'b1_001_1_1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_frame", {ifa.snap, ifa.ch_addr, ifa.sl, ifa.serial_out, ifa.frame_valid,
                                ifa.done, ifa.ovf_global, ifa.ovf_rtc, ifa.busy}, 11'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("post_rst_quiet", {ifa.busy, ifa.snap, ifa.done}, 3'b000);

        // Small instance: 2 channels of 4 bits.
        ifb.ovf_in   = 2'b10;
        ifb.rtc_tick = 1'b1;
        step();
        ifb.rtc_tick = 1'b0;
        bcyc = 0; busy_cnt = 0; nb = 0; saw1 = 1'b0; done_seen = 1'b0; bits = 10'd0;
        while (!done_seen && bcyc < 100) begin
            if (ifb.busy === 1'b1) busy_cnt++;
            if (ifb.frame_valid === 1'b1) begin
                bits = {bits[8:0], ifb.serial_out};
                nb++;
            end
            if (ifb.sl === 1'b1 && ifb.ch_addr === 1'b1) saw1 = 1'b1;
            if (ifb.done === 1'b1) done_seen = 1'b1;
            step();
            bcyc++;
        end
        check("b_done", done_seen, 1'b1);
        check("b_busy_len", 64'(busy_cnt), 64'd13);
        check("b_bits", 64'(nb), 64'd10);
        check("b_stream", bits, 10'b0_1010_1_1011);
        check("b_addr1", saw1, 1'b1);
        check("b_glob", ifb.ovf_global, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/impulse_readout_sequencer.md
# impulse_readout_sequencer

Readout controller for the multi-channel impulse counter bank. On each real-time-clock (RTC) tick it snapshots all channel counters. It then walks the channel address, loads each channel's count and overflow flag into a shift register, and streams the frame out serially. It owns the address lines, the snapshot strobe and the shift/load line. It also flags RTC ticks that arrive while a frame is still being sent.

## Interface

Parameters:
- `N_CH`, 8: number of counter channels, 2..16.
- `CNT_W`, 16: width of one channel count, 4..32.
- `ADDR_W`, `$clog2(N_CH)`: width of the channel address (derived, not overridden).

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: when low, new RTC ticks are ignored and not counted as missed; a frame already in progress completes.
- `rtc_tick`, in, 1: one-cycle request pulse, already synchronous to `clk`.
- `ovf_clr`, in, 1: one-cycle pulse that clears `ovf_rtc`.
- `cnt_data`, in, CNT_W: snapshot count of the channel at `ch_addr`, combinational from the bank.
- `ovf_in`, in, N_CH: per-channel overflow flags of the snapshot.
- `snap`, out, 1: one-cycle strobe; the bank copies live counts to the snapshot and clears the live counts.
- `ch_addr`, out, ADDR_W: address of the channel being read.
- `sl`, out, 1: shift/load; high for the single load cycle of each channel.
- `serial_out`, out, 1: frame data, MSB first.
- `frame_valid`, out, 1: high in every cycle where `serial_out` carries a data bit.
- `done`, out, 1: one-cycle pulse after the last bit of a frame.
- `ovf_global`, out, 1: OR of the `ovf_in` bits latched in the last frame.
- `ovf_rtc`, out, 1: sticky; set when an RTC tick is missed.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation

- **States:** IDLE, SNAP, LOAD, SHIFT.
- **IDLE:**
  - The tick is accepted when `rtc_tick & en` and the registered state is IDLE.
  - On acceptance: next state SNAP, channel index cleared to 0, `ovf_global` cleared.
- **SNAP:** `snap`=1 for one cycle, then go to LOAD.
- **LOAD:**
  - Outputs: `ch_addr`=index, `sl`=1.
  - Shift register ({`ovf_in[index]`, `cnt_data`}, CNT_W+1 bits) loads at the end of the cycle.
  - `ovf_global` |= `ovf_in[index]`.
  - Next state SHIFT with the bit counter at CNT_W.
- **SHIFT:**
  - Outputs: `serial_out` = shift-register MSB, `frame_valid`=1, `sl`=0, `ch_addr` held.
  - Each cycle: shift left, zero-fill, decrement the bit counter.
  - The cycle in which the counter is 0 carries the last bit (the count LSB).
  - After it: if index < N_CH−1, increment the index and go to LOAD; otherwise go to IDLE and pulse `done`.
- **Missed tick:** `rtc_tick & en` while `busy` sets `ovf_rtc`. The tick is otherwise dropped; it is never queued.
- **`ovf_rtc` set vs clear:** `ovf_clr` clears `ovf_rtc`. If set and clear occur in the same cycle, set wins.
- **Idle outputs:** when not in SHIFT, `serial_out`=0 and `frame_valid`=0.
- **Back-to-back frames:** a tick in the cycle where `done` is high is accepted, because the state is already IDLE.
- **Reset mid-frame:** the frame is abandoned immediately. No `done` is issued; the next frame needs a new tick.
- **Bus stability:** `ch_addr` is stable from LOAD through the end of that channel's SHIFT. The bank's `cnt_data` needs only to be valid during LOAD.

## Timing

- All outputs are registered.
- Reset values: all outputs 0 (`snap`, `ch_addr`, `sl`, `serial_out`, `frame_valid`, `done`, `ovf_global`, `ovf_rtc`, `busy`).
- Tick sampled high in IDLE at edge T:
  - `snap` and `busy` are high in cycle T+1.
  - First LOAD is in cycle T+2; the first data bit is in T+3.
- Each channel occupies CNT_W+2 cycles: 1 LOAD plus CNT_W+1 SHIFT.
- The frame's last bit is in cycle T+1+N_CH·(CNT_W+2).
- `done` is high and `busy` is low in the following cycle.
- Busy duration is 1+N_CH·(CNT_W+2) cycles; with the defaults this is 145.
- Minimum tick period without a miss: 2+N_CH·(CNT_W+2) cycles.

## Test plan

- **Reset:** assert `rst_n`=0 mid-SHIFT → all outputs are 0 immediately. After release, no activity occurs until a tick.
- **Single frame (defaults):**
  - Stimulus: bank model returns `cnt_data`=16'hA5C3+ch, `ovf_in`=8'h00, one tick.
  - Required: 8×17 bits, each channel sent as 0 followed by the count MSB first.
  - `done` exactly 145 cycles after `snap`; `sl` high exactly 8 times, with `ch_addr` 0..7.
  - `ovf_global`=0.
- **Overflow propagation:** `ovf_in`=8'h24 → the leading bit is 1 for channels 2 and 5 only; `ovf_global`=1 after the ch2 LOAD and stays 1 until the next accepted tick.
- **Missed tick:**
  - Second tick 50 cycles into a frame → `ovf_rtc`=1, the frame is unaffected, and no second frame starts.
  - `ovf_clr` asserted alone → `ovf_rtc`=0.
  - `ovf_clr` and a missed tick in the same cycle → `ovf_rtc`=1.
- **Boundary ticks:**
  - Tick on the `done` cycle → new `snap` on the next cycle, and `ovf_rtc` stays 0.
  - Tick with `en`=0 in IDLE → ignored, no flag.
- **Parameter sweep:** N_CH=2, CNT_W=4 → busy duration 13 cycles, `ch_addr` 1 bit wide, and the serial stream matches the model.
